// File: rtl/GEMM_pkg.sv
// Shared types and sizing helpers for the GEMM result collector.
package GEMM_pkg;

    localparam int DEF_SA_SIZE = 4;
    localparam int DEF_WA_SIZE = 8;

    typedef logic [DEF_WA_SIZE-1:0] lane_t;
    typedef lane_t [DEF_SA_SIZE-1:0] lane_vec_t;

    // Occupancy needs to represent 0..depth inclusive.
    function automatic int level_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int DEF_LEVEL_W = level_w(4);

endpackage

// File: rtl/gemm_result_collector_if.sv
// Handshake bundle between the GEMM array, the collector and its consumer.
interface gemm_result_collector_if #(
    parameter int SA_SIZE                = 4,
    parameter int WEIGHT_ACTIVATION_SIZE = 8,
    parameter int FIFO_DEPTH             = 4
) ();

    logic                                                in_valid;
    logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0]      in_data;
    logic                                                out_valid;
    logic                                                out_ready;
    logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0]      out_data;
    logic                                                out_last;
    logic [$clog2(FIFO_DEPTH+1)-1:0]                     level;
    logic                                                overflow;

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data, out_last, level, overflow
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data, out_last, level, overflow
    );

endinterface

// File: rtl/gemm_result_fifo.sv
// First-word fall-through FIFO; pointers carry a wrap bit to split full from empty.
module gemm_result_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage is intentionally not reset; contents are only meaningful below level.
    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = r_mem[r_rd_ptr[AW-1:0]];
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign level = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/gemm_result_collector.sv
// Buffers GEMM result rows, tags the last row of each matrix, flags drops.
// Optional GEMM_COLLECTOR_STATS_EN adds a 32-bit accepted-write counter.
module gemm_result_collector
    import GEMM_pkg::*;
#(
    parameter int SA_SIZE                = 4,
    parameter int WEIGHT_ACTIVATION_SIZE = 8,
    parameter int FIFO_DEPTH             = 4
) (
    input  logic                       clk,
    input  logic                       reset,
`ifdef GEMM_COLLECTOR_STATS_EN
    output logic [31:0]                result_count,
`endif
    gemm_result_collector_if.slave     bus
);

    localparam int WIDTH = SA_SIZE * WEIGHT_ACTIVATION_SIZE;
    localparam int LW    = level_w(FIFO_DEPTH);
    localparam int RW    = (SA_SIZE > 1) ? $clog2(SA_SIZE) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(SA_SIZE - 1);

    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [WIDTH-1:0] w_rdata;
    logic [LW-1:0]    w_level;
    logic [RW-1:0]    r_row;
    logic             r_overflow;

    assign w_pop  = !w_empty && bus.out_ready;
    // A full FIFO still takes the write when the head leaves in the same cycle.
    assign w_push = bus.in_valid && (!w_full || w_pop);
    assign w_drop = bus.in_valid && w_full && !w_pop;

    gemm_result_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (bus.in_data),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty),
        .level (w_level)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_row      <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_pop) r_row <= (r_row == LAST_ROW) ? '0 : r_row + 1'b1;
            if (w_drop) r_overflow <= 1'b1;
        end
    end

`ifdef GEMM_COLLECTOR_STATS_EN
    logic [31:0] r_result_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       r_result_count <= '0;
        else if (w_push) r_result_count <= r_result_count + 32'd1;
    end

    assign result_count = r_result_count;
`endif

    assign bus.out_valid = !w_empty;
    assign bus.out_data  = w_rdata;
    assign bus.out_last  = !w_empty && (r_row == LAST_ROW);
    assign bus.level     = w_level;
    assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_gemm_result_collector.sv
// Randomized and directed bench for gemm_result_collector against a queue model.
module tb_gemm_result_collector;

    localparam int SA = 2;
    localparam int W  = 8;
    localparam int D  = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

`ifdef GEMM_COLLECTOR_STATS_EN
    logic [31:0] result_count;
`endif

    gemm_result_collector_if #(
        .SA_SIZE(SA), .WEIGHT_ACTIVATION_SIZE(W), .FIFO_DEPTH(D)
    ) bus ();

    gemm_result_collector #(
        .SA_SIZE(SA), .WEIGHT_ACTIVATION_SIZE(W), .FIFO_DEPTH(D)
    ) dut (
        .clk          (clk),
        .reset        (reset),
`ifdef GEMM_COLLECTOR_STATS_EN
        .result_count (result_count),
`endif
        .bus          (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference: a plain queue of vectors, matrix row position and drop flag.
    logic [15:0] mq[$];
    int          mrow;
    bit          movf;
    int unsigned mcnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, ".valid"},    32'(bus.out_valid), 32'(mq.size() != 0));
        chk({ph, ".level"},    32'(bus.level),     32'(mq.size()));
        chk({ph, ".overflow"}, 32'(bus.overflow),  32'(movf));
        chk({ph, ".last"},     32'(bus.out_last),  32'(mq.size() != 0 && mrow == SA - 1));
        if (mq.size() != 0)
            chk({ph, ".data"}, 32'(bus.out_data), 32'(mq[0]));
`ifdef GEMM_COLLECTOR_STATS_EN
        chk({ph, ".count"}, result_count, mcnt);
`endif
    endtask

    // Called at a falling edge; applies inputs, advances the model, checks after the edge.
    task automatic step(input bit v, input logic [15:0] d, input bit rdy, input string ph);
        bit pop, full;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = rdy;
        pop  = (mq.size() != 0) && rdy;
        full = (mq.size() == D);
        if (pop) begin
            void'(mq.pop_front());
            mrow = (mrow + 1) % SA;
        end
        if (v) begin
            if (!full || pop) begin
                mq.push_back(d);
                mcnt++;
            end else begin
                movf = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_all(ph);
    endtask

    task automatic do_reset(input string ph);
        @(negedge clk);
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        mq.delete();
        mrow = 0;
        movf = 1'b0;
        mcnt = 0;
        #1;
        check_all({ph, ".async"});
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_all({ph, ".rel"});
        @(negedge clk);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        do_reset("por");

        // Two-row matrix streamed straight through.
        step(1'b1, {8'd6, 8'd10}, 1'b1, "pass0");
        step(1'b1, {8'd9, 8'd4},  1'b1, "pass1");
        step(1'b0, 16'h0,         1'b1, "pass2");
        step(1'b0, 16'h0,         1'b1, "pass3");

        // Fill, overflow, drain in order.
        do_reset("ovf");
        for (int i = 1; i <= 4; i++) step(1'b1, {8'(i), 8'(i)}, 1'b0, "fill");
        step(1'b1, {8'd5, 8'd5}, 1'b0, "drop");
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b1, "drain");

        // Push into a full FIFO while popping, then hold the head.
        do_reset("fp");
        for (int i = 1; i <= 4; i++) step(1'b1, {8'(i), 8'(i + 16)}, 1'b0, "fill2");
        step(1'b1, {8'd7, 8'd7}, 1'b1, "fullpop");
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b0, "hold");

        // Reset mid-matrix drops the partial row count.
        do_reset("mid");
        for (int i = 1; i <= 4; i++) step(1'b1, {8'(i), 8'(i)}, 1'b0, "fill3");
        step(1'b0, 16'h0, 1'b1, "pop1");
        do_reset("mid2");
        step(1'b1, {8'd8, 8'd8}, 1'b0, "after");
        chk("after.last0", 32'(bus.out_last), 32'd0);
        step(1'b0, 16'h0, 1'b1, "after.pop");

`ifdef GEMM_COLLECTOR_STATS_EN
        do_reset("stats");
        for (int i = 0; i < 5; i++) step(1'b1, 16'(i + 1), 1'b0, "stpush");
        chk("stats.count4", result_count, 32'd4);
`endif

        do_reset("rnd");
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 99) < 60, 16'($urandom), 1'($urandom_range(0, 1)), "rnd");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gemm_result_collector.md
GEMM_RESULT_COLLECTOR -- requirements
Module: gemm_result_collector

Interface
REQ-001 The block SHALL have parameter SA_SIZE, default 4, giving the number of result lanes (the systolic array width).
REQ-002 The block SHALL have parameter WEIGHT_ACTIVATION_SIZE, default 8, giving the bits per lane.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, giving the result vectors buffered; it is a power of 2 and at least 2.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset is asynchronous and active-high.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the GEMM output_valid strobe; there is no backpressure toward the GEMM.
REQ-007 The block SHALL have port in_data, input, SA_SIZE x WEIGHT_ACTIVATION_SIZE: the GEMM activation_outputs vector.
REQ-008 The block SHALL have port out_valid, output, 1 bit: a result vector is presented.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the vector.
REQ-010 The block SHALL have port out_data, output, SA_SIZE x WEIGHT_ACTIVATION_SIZE: the presented result vector.
REQ-011 The block SHALL have port out_last, output, 1 bit: marks the final row of each SA_SIZE-row result matrix.
REQ-012 The block SHALL have port level, output, $clog2(FIFO_DEPTH+1) bits: the current FIFO occupancy.
REQ-013 The block SHALL have port overflow, output, 1 bit: sticky flag set when a result vector was dropped.

Function
REQ-014 Write: on a rising edge with in_valid=1 and the FIFO not full, the block SHALL store in_data unmodified at the tail.
REQ-015 Full with simultaneous pop: when in_valid=1, the FIFO is full and out_valid&&out_ready, the block SHALL accept the write; level SHALL stay FIFO_DEPTH.
REQ-016 Full without pop: when in_valid=1, the FIFO is full and no pop occurs, the block SHALL drop the vector, set overflow to 1, and leave level and contents unchanged.
REQ-017 Empty: out_valid SHALL equal (level!=0); there is no combinational bypass, so a vector written at edge N appears on out_data after edge N.
REQ-018 Pop: out_valid&&out_ready at an edge SHALL remove the head vector.
REQ-019 out_data SHALL always show the head entry (first-word fall-through) and SHALL hold stable while out_valid=1 and out_ready=0.
REQ-020 Simultaneous push and pop on a non-empty, non-full FIFO SHALL leave level unchanged.
REQ-021 Pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be distinguished by an extra pointer wrap bit.
REQ-022 Row counter: a counter SHALL run 0..SA_SIZE-1, advance only on a pop, and wrap to 0 after SA_SIZE-1; dropped vectors SHALL NOT advance it.
REQ-023 out_last SHALL equal out_valid && (row counter == SA_SIZE-1).
REQ-024 Once set, overflow SHALL remain 1 until reset.

Reset
REQ-025 While reset=1, asynchronously: both pointers, level and the row counter SHALL be 0, overflow SHALL be 0, and out_valid and out_last SHALL be 0.
REQ-026 FIFO storage SHALL NOT be reset; out_data is don't-care while out_valid=0.
REQ-027 Reset asserted mid-operation SHALL discard all buffered vectors and the partial matrix row count.

Configuration
REQ-028 With GEMM_COLLECTOR_STATS_EN defined, the block SHALL add output result_count, 32 bits, reset to 0, incremented on every accepted write (including a write accepted under REQ-015), and wrapping from 2^32-1 to 0.
REQ-029 Without GEMM_COLLECTOR_STATS_EN, the result_count port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-030 GEMM_pkg SHALL hold the lane vector typedef (an array of SA_SIZE logic[WEIGHT_ACTIVATION_SIZE-1:0]) and the level-width helper constant.
REQ-031 Storage and pointers SHALL live in sub-module gemm_result_fifo (parameters WIDTH and DEPTH; push, pop, full, empty, level); the top SHALL hold the row counter, overflow, out_last and stats logic.

Verification
REQ-032 Use SA_SIZE=2, FIFO_DEPTH=4. Push {6,10} then {9,4} with out_ready=1 -> out_data {6,10} (out_last=0), then {9,4} (out_last=1); level returns to 0.
REQ-033 out_ready=0 while pushing 4 vectors {1,1}..{4,4} -> level=4 and overflow=0; a 5th push gives overflow=1 and level=4; draining yields {1,1},{2,2},{3,3},{4,4} in order.
REQ-034 With the FIFO full, in_valid=1 and out_ready=1 in the same cycle -> new vector accepted, level stays 4, overflow stays 0.
REQ-035 Hold out_ready=0 with out_valid=1 for 3 cycles -> out_data and out_last stable throughout.
REQ-036 Assert reset after 1 of 2 rows are popped and 3 vectors are buffered -> level=0, out_valid=0, overflow=0; the next popped vector has out_last=0.
REQ-037 With GEMM_COLLECTOR_STATS_EN: 5 pushes into a full FIFO with no pops -> result_count=4; without the macro the same bench compiles with no result_count port.
